// File: rtl/stepgen_axi_pkg.sv
// Purpose: shared constants and helpers for the TMC5130A step-generator AXI4-Lite register file.
// Latency: not applicable (constants and a combinational byte-merge helper only).
// Backpressure: not applicable.
package stepgen_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers 0..NUM_RW_REGS-1 are writable; everything above is read-only or unmapped.
  localparam int NUM_RW_REGS = 4;

  // Word index = byte address [4:2].
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_XTARGET  = 3'd1,
    REG_VMAX     = 3'd2,
    REG_AMAX     = 3'd3,
    REG_XACTUAL  = 3'd4,
    REG_STATUS   = 3'd5,
    REG_ID       = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_idx_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stepgen_axi_lite_regs.sv
// Purpose: AXI4-Lite responder holding the step generator's CTRL/XTARGET/VMAX/AMAX registers plus RO XACTUAL/STATUS/ID.
// Latency: write executes one cycle after both AW and W are held (BVALID + pulse that cycle); read data one cycle after AR.
// Backpressure: AW/W each hold one beat and stall while full; B and R are held until BREADY/RREADY; one read outstanding.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         write address / data / response channels
//   S_AXI_AR*/R*            read address / data channels
//   ctrl_o..amax_o          current RW register contents
//   reg_wr_pulse_o          one-cycle pulse per RW register on write execution
//   xactual_i, status_i     read-only position and status from the core
module stepgen_axi_lite_regs
  import stepgen_axi_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE         = 32'h5130_0100
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     ctrl_o,
  output logic [31:0]                     xtarget_o,
  output logic [31:0]                     vmax_o,
  output logic [31:0]                     amax_o,
  output logic [NUM_RW_REGS-1:0]          reg_wr_pulse_o,
  input  logic [31:0]                     xactual_i,
  input  logic [7:0]                      status_i
);

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------- write path
  logic                   aw_held;
  logic [2:0]             aw_idx;
  logic                   w_held;
  logic [31:0]            w_data;
  logic [3:0]             w_strb;
  logic                   bvalid;
  logic [1:0]             bresp;
  logic [NUM_RW_REGS-1:0] pulse;
  logic [31:0]            ex_data;
  logic [3:0]             ex_strb;
  logic [31:0]            rw_q [NUM_RW_REGS];

  logic aw_hs;
  logic w_hs;
  logic exec;

  // Ready falls during reset without waiting for a clock edge.
  assign S_AXI_AWREADY = ~ARESET & ~aw_held;
  assign S_AXI_WREADY  = ~ARESET & ~w_held;
  assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID & S_AXI_WREADY;
  // A new write waits until the previous response has been taken.
  assign exec          = aw_held & w_held & ~bvalid;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      pulse   <= '0;
      ex_data <= '0;
      ex_strb <= '0;
      for (int n = 0; n < NUM_RW_REGS; n++) rw_q[n] <= '0;
    end else begin
      // aw_hs needs an empty slot and exec a full one, so they never coincide.
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[4:2];
      end else if (exec) begin
        aw_held <= 1'b0;
      end

      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (exec) begin
        w_held <= 1'b0;
      end

      if (exec) begin
        bvalid  <= 1'b1;
        bresp   <= (aw_idx < 3'(NUM_RW_REGS)) ? RESP_OKAY : RESP_SLVERR;
        ex_data <= w_data;
        ex_strb <= w_strb;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end

      for (int n = 0; n < NUM_RW_REGS; n++) begin
        pulse[n] <= exec && (aw_idx == 3'(n));
      end

      // The pulse cycle is the execution cycle; the new value lands at its end,
      // so a read accepted in that same cycle still sees the old contents.
      for (int n = 0; n < NUM_RW_REGS; n++) begin
        if (pulse[n]) rw_q[n] <= merge_wstrb(rw_q[n], ex_data, ex_strb);
      end
    end
  end

  assign S_AXI_BVALID   = bvalid;
  assign S_AXI_BRESP    = bresp;
  assign reg_wr_pulse_o = pulse;
  assign ctrl_o         = rw_q[REG_CTRL];
  assign xtarget_o      = rw_q[REG_XTARGET];
  assign vmax_o         = rw_q[REG_VMAX];
  assign amax_o         = rw_q[REG_AMAX];

  // ----------------------------------------------------------------- read path
  reg_idx_e    ar_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        ar_hs;

  assign ar_idx        = reg_idx_e'(S_AXI_ARADDR[4:2]);
  assign S_AXI_ARREADY = ~ARESET & ~rvalid;
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      REG_CTRL:    rd_data = rw_q[REG_CTRL];
      REG_XTARGET: rd_data = rw_q[REG_XTARGET];
      REG_VMAX:    rd_data = rw_q[REG_VMAX];
      REG_AMAX:    rd_data = rw_q[REG_AMAX];
      REG_XACTUAL: rd_data = xactual_i;
      REG_STATUS:  rd_data = {24'b0, status_i};
      REG_ID:      rd_data = C_ID_VALUE;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = rresp;

endmodule

// File: tb/tb_stepgen_axi_lite_regs.sv
// Purpose: self-checking bench for stepgen_axi_lite_regs against a register-map reference model.
// Latency: directed plan items first, then randomized reads/writes with random channel skew and stalls.
// Backpressure: BREADY/RREADY are held low for random stretches to exercise response holding.
module tb_stepgen_axi_lite_regs;

  localparam logic [31:0] ID_VALUE = 32'h5130_0100;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [31:0] ctrl_o, xtarget_o, vmax_o, amax_o;
  logic [3:0]  reg_wr_pulse_o;
  logic [31:0] xactual_i = '0;
  logic [7:0]  status_i = '0;

  stepgen_axi_lite_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_o(ctrl_o), .xtarget_o(xtarget_o), .vmax_o(vmax_o), .amax_o(amax_o),
    .reg_wr_pulse_o(reg_wr_pulse_o),
    .xactual_i(xactual_i), .status_i(status_i)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Every cycle with any write pulse is logged, so a stretched pulse shows up twice.
  logic [3:0] pq_val[$];
  int         pq_cyc[$];
  always @(negedge ACLK) begin
    if (reg_wr_pulse_o !== 4'b0) begin
      pq_val.push_back(reg_wr_pulse_o);
      pq_cyc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [31:0] m_rw [4];

  function automatic void m_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int i;
    i = int'(a) / 4;
    r = OKAY;
    d = 32'h0;
    if (i < 4)       d = m_rw[i];
    else if (i == 4) d = xactual_i;
    else if (i == 5) d = {24'h0, status_i};
    else if (i == 6) d = ID_VALUE;
    else             r = SLVERR;
  endfunction

  function automatic void m_write(input int i, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    m_rw[i] = (m_rw[i] & ~mask) | (d & mask);
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_ctrl"},    ctrl_o,    m_rw[0]);
    chk({tag, "_xtarget"}, xtarget_o, m_rw[1]);
    chk({tag, "_vmax"},    vmax_o,    m_rw[2]);
    chk({tag, "_amax"},    amax_o,    m_rw[3]);
  endtask

  // ------------------------------------------------------------ bus helpers
  int aw_cyc = 0;
  int w_cyc  = 0;

  task automatic send_aw(input logic [4:0] a, input int dly);
    bit done = 0;
    repeat (dly) @(posedge ACLK);
    #1 S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        aw_cyc = cyc;
        done = 1;
      end
    end
    if (!done) begin
      chk("aw_timeout", 32'd0, 32'd1);
      S_AXI_AWVALID = 1'b0;
    end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit done = 0;
    repeat (dly) @(posedge ACLK);
    #1 S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge ACLK);
      if (S_AXI_WREADY) begin
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        w_cyc = cyc;
        done = 1;
      end
    end
    if (!done) begin
      chk("w_timeout", 32'd0, 32'd1);
      S_AXI_WVALID = 1'b0;
    end
  endtask

  // Waits for B, holds BREADY low for 'hold' cycles, then takes the response.
  task automatic get_b(input int hold, input logic [1:0] exp_resp, output int vcyc);
    bit seen = 0;
    vcyc = -100;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) seen = 1;
    end
    if (!seen) begin
      chk("b_timeout", 32'd0, 32'd1);
    end else begin
      vcyc = cyc;
      chk("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
      for (int k = 0; k < hold; k++) begin
        @(negedge ACLK);
        chk("b_hold_vld",  32'(S_AXI_BVALID), 32'd1);
        chk("b_hold_resp", 32'(S_AXI_BRESP), 32'(exp_resp));
      end
      @(posedge ACLK); #1 S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
      @(negedge ACLK);
      chk("b_done", 32'(S_AXI_BVALID), 32'd0);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_hold);
    int          i;
    int          bcyc;
    int          last;
    logic [1:0]  exp_resp;
    logic [3:0]  exp_pulse;
    i = int'(a) / 4;
    exp_resp  = (i < 4) ? OKAY : SLVERR;
    exp_pulse = (i < 4) ? 4'(1 << i) : 4'b0;
    pq_val.delete();
    pq_cyc.delete();
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    get_b(b_hold, exp_resp, bcyc);
    last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
    chk("b_latency", 32'(bcyc - last), 32'd1);
    if (exp_pulse != 4'b0) begin
      chk("pulse_count", 32'(pq_val.size()), 32'd1);
      if (pq_val.size() > 0) begin
        chk("pulse_val", 32'(pq_val[0]), 32'(exp_pulse));
        chk("pulse_cyc", 32'(pq_cyc[0] - last), 32'd1);
      end
      m_write(i, d, s);
    end else begin
      chk("pulse_none", 32'(pq_val.size()), 32'd0);
    end
    chk_regs("wr");
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [4:0] a, input int ar_dly, input int r_hold);
    logic [31:0] ed;
    logic [1:0]  er;
    bit          done = 0;
    bit          seen = 0;
    int          arc = 0;
    m_read(a, ed, er);
    repeat (ar_dly) @(posedge ACLK);
    #1 S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        arc = cyc;
        done = 1;
      end
    end
    if (!done) begin
      chk("ar_timeout", 32'd0, 32'd1);
      S_AXI_ARVALID = 1'b0;
    end else begin
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge ACLK);
        if (S_AXI_RVALID) seen = 1;
      end
      if (!seen) begin
        chk("r_timeout", 32'd0, 32'd1);
      end else begin
        chk("r_vld_delay", 32'(cyc - arc), 32'd0);
        chk("rdata", S_AXI_RDATA, ed);
        chk("rresp", 32'(S_AXI_RRESP), 32'(er));
        for (int k = 0; k < r_hold; k++) begin
          @(negedge ACLK);
          chk("r_hold_vld",  32'(S_AXI_RVALID), 32'd1);
          chk("r_hold_data", S_AXI_RDATA, ed);
          chk("r_hold_resp", 32'(S_AXI_RRESP), 32'(er));
          chk("r_hold_arrdy", 32'(S_AXI_ARREADY), 32'd0);
        end
        @(posedge ACLK); #1 S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        chk("r_done", 32'(S_AXI_RVALID), 32'd0);
      end
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          nb;
    bit          seen;
    logic [31:0] d;
    logic [3:0]  s;
    for (int n = 0; n < 4; n++) m_rw[n] = 32'h0;

    // Reset state
    @(negedge ACLK);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    chk("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
    chk("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
    chk("rst_rdata",   S_AXI_RDATA,        32'd0);
    chk("rst_pulse",   32'(reg_wr_pulse_o), 32'd0);
    chk_regs("rst");
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;

    // AW and W together, readback
    do_write(5'h00, 32'h0101_FFFF, 4'hF, 0, 0, 0);
    do_read(5'h00, 0, 0);
    // W leads AW by 3 cycles, B held 5 cycles
    do_write(5'h04, 32'hABCD_0001, 4'hF, 3, 0, 5);
    // Partial strobe
    do_write(5'h08, 32'hDEAD_0011, 4'hF, 0, 0, 0);
    do_write(5'h08, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0);
    chk("vmax_partial", vmax_o, 32'hDEAD_FFFF);
    // Read-only / unmapped
    do_write(5'h18, 32'h1111_2222, 4'hF, 0, 1, 0);
    do_write(5'h1C, 32'h3333_4444, 4'hF, 2, 0, 1);
    do_read(5'h18, 0, 0);
    do_read(5'h1C, 0, 2);
    xactual_i = 32'h1234_5678;
    status_i  = 8'hA5;
    do_read(5'h10, 0, 0);
    do_read(5'h14, 0, 0);
    // Empty strobe: OKAY, pulse, no change
    do_write(5'h00, 32'h5555_5555, 4'h0, 0, 0, 0);
    // Plan loop then readback
    do_write(5'h00, 32'h0101_FFFF, 4'hF, 0, 0, 0);
    do_write(5'h04, 32'hABCD_0001, 4'hF, 1, 0, 0);
    do_write(5'h08, 32'hDEAD_0011, 4'hF, 0, 1, 0);
    do_write(5'h0C, 32'hBEEF_0011, 4'hF, 0, 0, 2);
    for (int k = 0; k < 4; k++) do_read(5'(k * 4), 0, 0);

    // Read accepted in the execution cycle of a write to the same register sees the old value
    fork
      do_write(5'h00, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      do_read(5'h01, 2, 0);
    join

    // Sustained write throughput with BREADY high: one per two cycles
    pq_val.delete(); pq_cyc.delete();
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h7777_0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) nb++;
    end
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 S_AXI_BREADY = 1'b0;
    chk("wr_throughput", 32'(nb), 32'd4);
    m_rw[1] = 32'h7777_0001;
    chk_regs("wr_tp");

    // Sustained read throughput with RREADY high: one per two cycles
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 5'h18; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        nb++;
        chk("rd_tp_data", S_AXI_RDATA, ID_VALUE);
      end
    end
    @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 S_AXI_RREADY = 1'b0;
    chk("rd_throughput", 32'(nb), 32'd5);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      xactual_i = $urandom;
      status_i  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        do_write(5'($urandom_range(0, 31)), d, s,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 3));
      end
    end

    // Reset while a write response is pending
    pq_val.delete(); pq_cyc.delete();
    fork
      send_aw(5'h0C, 0);
      send_w(32'h1357_9BDF, 4'hF, 0);
    join
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) seen = 1;
    end
    chk("rst_mid_bvalid_seen", 32'(seen), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("rst_mid_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_mid_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_mid_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_mid_pulse",   32'(reg_wr_pulse_o), 32'd0);
    for (int n = 0; n < 4; n++) m_rw[n] = 32'h0;
    chk_regs("rst_mid");
    @(posedge ACLK); @(posedge ACLK);
    #1 ARESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      chk("post_rst_no_b", 32'(S_AXI_BVALID), 32'd0);
      chk("post_rst_no_r", 32'(S_AXI_RVALID), 32'd0);
    end
    @(posedge ACLK); #1;
    do_read(5'h0C, 0, 0);
    do_read(5'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
